fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- PC generator plus IF/ID pipeline register.
- Drives the instruction-memory address and captures its instruction word and fetch exception code.
- Presents a registered decode-stage bundle: instr, pc, exccode, delay-slot flag, valid.
- Applies redirects: exception, eret, branch/jump. Applies stall and flush.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, exception/interrupt handler entry.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC and IF/ID contents (load-use or MDU busy).
- exc_req  input  1  exception/interrupt taken in a later stage; redirect to EXC_VECTOR.
- eret_req  input  1  eret committed; redirect to epc.
- epc  input  32  return address for eret.
- br_taken_D  input  1  branch/jump in D resolved taken.
- br_target_D  input  32  target address for the taken branch/jump.
- is_br_D  input  1  instruction in D is a branch/jump, so the F instruction is its delay slot.
- Addr  output  32  fetch address to instruction memory; equals pc_F.
- instr_F  input  32  word returned by instruction memory.
- exccode_F  input  5  fetch exception code from instruction memory; 0 = none, 5'h4 = AdEL.
- instr_D  output  32  registered instruction.
- pc_D  output  32  registered PC.
- exccode_D  output  5  registered fetch exception code.
- bd_D  output  1  registered delay-slot flag.
- valid_D  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (reset=0, async):
  - pc_F = RESET_PC.
  - instr_D = 0, pc_D = 0, exccode_D = 0, bd_D = 0, valid_D = 0.
  - FSM -> BOOT.
- FSM states:
  - BOOT: first edge after reset release. IF/ID loads the fetch at RESET_PC with valid_D=1, pc_F advances, FSM -> RUN.
  - RUN: normal operation.
  - HANDLER: entered one edge after exc_req. Behaves like RUN. Returns to RUN on eret_req. Exposed only for debug/verification; has no effect on datapath.
- next-PC priority on each rising edge, highest first:
  1. exc_req: pc_F <= EXC_VECTOR; IF/ID flushed (all zero, valid_D=0).
  2. eret_req: pc_F <= epc; IF/ID flushed. eret has no delay slot.
  3. stall: pc_F and IF/ID hold. br_taken_D is ignored; it stays asserted while D is stalled and is consumed after the stall.
  4. br_taken_D: pc_F <= br_target_D; IF/ID loads the current F instruction (delay slot) with bd_D=1.
  5. Otherwise: pc_F <= pc_F + 4, with 32-bit wrap.
- IF/ID load (cases 4 and 5):
  - instr_D <= (exccode_F != 0) ? 0 : instr_F.
  - pc_D <= pc_F.
  - exccode_D <= exccode_F.
  - bd_D <= is_br_D.
  - valid_D <= 1.
- A faulting fetch (misaligned or out-of-range pc_F) is not trapped here. Its exccode rides to D; pc_F keeps advancing until a later stage asserts exc_req.
- exc_req and eret_req together: exc_req wins and the FSM goes to HANDLER.
- Addr is combinational from pc_F. Zero-cycle latency to memory; one-cycle latency into D.

Optional Feature:
- Macro: FETCH_CNT_EN.
- Defined:
  - Adds output fetch_cnt (32 bits), reset 0.
  - Increments by 1 on every edge where IF/ID loads with valid_D=1. Stalls and flushes do not count.
  - Wraps from 32'hFFFF_FFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset release, no stall, instr_F = 32'h2408_0001 -> Addr 3000, 3004, 3008 on successive edges. First edge gives pc_D=3000, valid_D=1, bd_D=0.
2. is_br_D=1 with br_taken_D=1, br_target_D=32'h0000_3040 while pc_F=3008 -> pc_D=3008 with bd_D=1; next Addr=3040.
3. stall=1 for 3 cycles with br_taken_D=1 held -> Addr and IF/ID frozen. On stall release, Addr=br_target_D.
4. Addr driven to 3002 so exccode_F=4 -> instr_D=0, exccode_D=4, valid_D=1. Then exc_req=1 -> Addr=4180, valid_D=0, FSM=HANDLER.
5. exc_req=1 and eret_req=1 in the same cycle, epc=3010 -> Addr=4180. A following eret_req alone -> Addr=3010, IF/ID flushed, FSM=RUN.
6. reset asserted mid-run with pc_F=3100 -> immediately pc_F=3000 and valid_D=0, without a clock edge. With FETCH_CNT_EN defined, fetch_cnt=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: pipeline control, instruction-memory port and
// the registered IF/ID decode bundle. The master side is the fetch stage;
// the slave side is the surrounding pipeline and instruction memory.
interface fetch_stage_if;
  logic        stall;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        br_taken_D;
  logic [31:0] br_target_D;
  logic        is_br_D;
  logic [31:0] Addr;
  logic [31:0] instr_F;
  logic [4:0]  exccode_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [4:0]  exccode_D;
  logic        bd_D;
  logic        valid_D;

  modport master (
    input  stall, exc_req, eret_req, epc, br_taken_D, br_target_D, is_br_D,
    input  instr_F, exccode_F,
    output Addr, instr_D, pc_D, exccode_D, bd_D, valid_D
  );

  modport slave (
    output stall, exc_req, eret_req, epc, br_taken_D, br_target_D, is_br_D,
    output instr_F, exccode_F,
    input  Addr, instr_D, pc_D, exccode_D, bd_D, valid_D
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC generator plus IF/ID pipeline register.
// Redirect priority: exception, eret, stall, taken branch, sequential.
// Optional macro FETCH_CNT_EN adds a 32-bit count of valid IF/ID loads.
// dbg_state exposes the BOOT/RUN/HANDLER tracker for debug only.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus,
  output logic [1:0]    dbg_state
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]   fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_D_q, instr_D_d;
  logic [31:0] pc_D_q, pc_D_d;
  logic [4:0]  exccode_D_q, exccode_D_d;
  logic        bd_D_q, bd_D_d;
  logic        valid_D_q, valid_D_d;
  logic        doFlush;
  logic        doLoad;

  // A redirect from a later stage flushes IF/ID; otherwise it loads unless stalled.
  always_comb begin
    doFlush = bus.exc_req | bus.eret_req;
    doLoad  = ~doFlush & ~bus.stall;
  end

  // Next PC and next IF/ID contents, highest-priority redirect first.
  always_comb begin
    pc_d        = pc_q;
    instr_D_d   = instr_D_q;
    pc_D_d      = pc_D_q;
    exccode_D_d = exccode_D_q;
    bd_D_d      = bd_D_q;
    valid_D_d   = valid_D_q;
    if (bus.exc_req || bus.eret_req) begin
      pc_d        = bus.exc_req ? EXC_VECTOR : bus.epc;
      instr_D_d   = 32'h0;
      pc_D_d      = 32'h0;
      exccode_D_d = 5'h0;
      bd_D_d      = 1'b0;
      valid_D_d   = 1'b0;
    end else if (doLoad) begin
      pc_d        = bus.br_taken_D ? bus.br_target_D : pc_q + 32'd4;
      instr_D_d   = (bus.exccode_F != 5'h0) ? 32'h0 : bus.instr_F;
      pc_D_d      = pc_q;
      exccode_D_d = bus.exccode_F;
      bd_D_d      = bus.is_br_D;
      valid_D_d   = 1'b1;
    end
  end

  // Mode tracker: leaves BOOT after the first edge, follows exception/eret.
  always_comb begin
    state_d = state_q;
    if (bus.exc_req) begin
      state_d = HANDLER;
    end else if (bus.eret_req) begin
      state_d = RUN;
    end else if (state_q == BOOT) begin
      state_d = RUN;
    end
  end

  // PC, IF/ID and mode registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      instr_D_q   <= 32'h0;
      pc_D_q      <= 32'h0;
      exccode_D_q <= 5'h0;
      bd_D_q      <= 1'b0;
      valid_D_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_D_q   <= instr_D_d;
      pc_D_q      <= pc_D_d;
      exccode_D_q <= exccode_D_d;
      bd_D_q      <= bd_D_d;
      valid_D_q   <= valid_D_d;
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count only edges where IF/ID captures a real instruction; wraps naturally.
  always_comb begin
    cnt_d = doLoad ? cnt_q + 32'd1 : cnt_q;
  end

  // Fetch counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 32'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_cnt = cnt_q;
`endif

  assign bus.Addr      = pc_q;
  assign bus.instr_D   = instr_D_q;
  assign bus.pc_D      = pc_D_q;
  assign bus.exccode_D = exccode_D_q;
  assign bus.bd_D      = bd_D_q;
  assign bus.valid_D   = valid_D_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized control traffic checked every cycle against
// a behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
   localparam logic [1:0]  ST_BOOT    = 2'd0;
   localparam logic [1:0]  ST_RUN     = 2'd1;
   localparam logic [1:0]  ST_HANDLER = 2'd2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  dbgState;
   logic [31:0] fetchCnt;

   fetch_stage_if bus();

   int nAssert = 0;
   int nFail   = 0;

   // Behavioural model state
   logic [31:0] mPc;
   logic [31:0] mInstrD;
   logic [31:0] mPcD;
   logic [4:0]  mExcD;
   logic        mBdD;
   logic        mValidD;
   logic [1:0]  mState;
   logic [31:0] mCnt;

   fetch_stage #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
      .clk       (clock),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbgState)
`ifdef FETCH_CNT_EN
      ,
      .fetch_cnt (fetchCnt)
`endif
   );

`ifndef FETCH_CNT_EN
   assign fetchCnt = 32'h0;
`endif

   // Free-running clock, 10 time-unit period
   always #5 clock = ~clock;

   // Instruction-memory content: a distinct word per address, AdEL on misalignment
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'h2408_0001;
   endfunction

   function automatic logic [4:0] memExc(input logic [31:0] a);
      return (a[1:0] != 2'b00) ? 5'h4 : 5'h0;
   endfunction

   // The bench plays instruction memory, answering combinationally from Addr
   always_comb begin
      bus.instr_F   = memWord(bus.Addr);
      bus.exccode_F = memExc(bus.Addr);
   end

   // Model reset: PC at the boot address, empty decode slot, count cleared
   task automatic modelReset();
      mPc     = RESET_PC;
      mInstrD = 32'h0;
      mPcD    = 32'h0;
      mExcD   = 5'h0;
      mBdD    = 1'b0;
      mValidD = 1'b0;
      mState  = ST_BOOT;
      mCnt    = 32'h0;
   endtask

   // Model one rising edge from the bench-driven control inputs
   task automatic modelEdge();
      if (bus.exc_req || bus.eret_req) begin
         mPc     = bus.exc_req ? EXC_VECTOR : bus.epc;
         mState  = bus.exc_req ? ST_HANDLER : ST_RUN;
         mInstrD = 32'h0;
         mPcD    = 32'h0;
         mExcD   = 5'h0;
         mBdD    = 1'b0;
         mValidD = 1'b0;
      end else begin
         if (mState == ST_BOOT) mState = ST_RUN;
         if (!bus.stall) begin
            mExcD   = memExc(mPc);
            mInstrD = (mExcD != 5'h0) ? 32'h0 : memWord(mPc);
            mPcD    = mPc;
            mBdD    = bus.is_br_D;
            mValidD = 1'b1;
            mCnt    = mCnt + 32'd1;
            mPc     = bus.br_taken_D ? bus.br_target_D : mPc + 32'd4;
         end
      end
   endtask

   // One counted comparison
   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model
   task automatic checkOutput();
      checkVal("Addr",      bus.Addr,              mPc);
      checkVal("instr_D",   bus.instr_D,           mInstrD);
      checkVal("pc_D",      bus.pc_D,              mPcD);
      checkVal("exccode_D", {27'h0, bus.exccode_D}, {27'h0, mExcD});
      checkVal("bd_D",      {31'h0, bus.bd_D},     {31'h0, mBdD});
      checkVal("valid_D",   {31'h0, bus.valid_D},  {31'h0, mValidD});
      checkVal("state",     {30'h0, dbgState},     {30'h0, mState});
`ifdef FETCH_CNT_EN
      checkVal("fetch_cnt", fetchCnt,              mCnt);
`endif
   endtask

   // Drive one cycle of controls, step the model on the edge, check on the falling edge
   task automatic applyStimulus(input logic stall, input logic exc, input logic eret,
                                input logic [31:0] epc, input logic br,
                                input logic [31:0] tgt, input logic isBr);
      bus.stall       = stall;
      bus.exc_req     = exc;
      bus.eret_req    = eret;
      bus.epc         = epc;
      bus.br_taken_D  = br;
      bus.br_target_D = tgt;
      bus.is_br_D     = isBr;
      @(posedge clock);
      modelEdge();
      @(negedge clock);
      checkOutput();
   endtask

   // Directed scenarios followed by randomized traffic
   initial begin
      logic [31:0] tgt;
      logic [31:0] epcR;
      bus.stall = 0; bus.exc_req = 0; bus.eret_req = 0; bus.epc = 0;
      bus.br_taken_D = 0; bus.br_target_D = 0; bus.is_br_D = 0;
      modelReset();
      @(negedge clock);
      @(negedge clock);
      checkOutput();
      checkVal("resetAddr", bus.Addr, 32'h0000_3000);
      reset = 1'b1;

      // Sequential fetch from the boot address
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkVal("bootPcD",   bus.pc_D, 32'h0000_3000);
      checkVal("bootValid", {31'h0, bus.valid_D}, 32'h1);
      checkVal("bootAddr",  bus.Addr, 32'h0000_3004);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkVal("seqAddr",   bus.Addr, 32'h0000_3008);

      // Taken branch: current fetch is its delay slot
      applyStimulus(0, 0, 0, 0, 1, 32'h0000_3040, 1);
      checkVal("brPcD",  bus.pc_D, 32'h0000_3008);
      checkVal("brBd",   {31'h0, bus.bd_D}, 32'h1);
      checkVal("brAddr", bus.Addr, 32'h0000_3040);

      // Stall with a pending branch holds everything
      repeat (3) applyStimulus(1, 0, 0, 0, 1, 32'h0000_3080, 1);
      checkVal("stallAddr", bus.Addr, 32'h0000_3040);
      checkVal("stallPcD",  bus.pc_D, 32'h0000_3008);
      applyStimulus(0, 0, 0, 0, 1, 32'h0000_3080, 1);
      checkVal("unstallAddr", bus.Addr, 32'h0000_3080);

      // Misaligned fetch rides its AdEL code into D, then the exception redirects
      applyStimulus(0, 0, 0, 0, 1, 32'h0000_3002, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkVal("adelInstr", bus.instr_D, 32'h0);
      checkVal("adelExc",   {27'h0, bus.exccode_D}, 32'h4);
      checkVal("adelValid", {31'h0, bus.valid_D}, 32'h1);
      checkVal("adelAddr",  bus.Addr, 32'h0000_3006);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkVal("excAddr",  bus.Addr, 32'h0000_4180);
      checkVal("excValid", {31'h0, bus.valid_D}, 32'h0);
      checkVal("excState", {30'h0, dbgState}, 32'h2);

      // Exception beats eret; a lone eret returns to epc
      applyStimulus(0, 1, 1, 32'h0000_3010, 0, 0, 0);
      checkVal("bothAddr",  bus.Addr, 32'h0000_4180);
      checkVal("bothState", {30'h0, dbgState}, 32'h2);
      applyStimulus(0, 0, 1, 32'h0000_3010, 0, 0, 0);
      checkVal("eretAddr",  bus.Addr, 32'h0000_3010);
      checkVal("eretValid", {31'h0, bus.valid_D}, 32'h0);
      checkVal("eretState", {30'h0, dbgState}, 32'h1);

      // PC wraps at the top of the address space
      applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkVal("wrapAddr", bus.Addr, 32'h0000_0000);

      // Randomized control traffic with occasional misaligned targets
      for (int i = 0; i < 400; i++) begin
         tgt  = $urandom;
         epcR = $urandom;
         if ($urandom_range(0, 7) != 0) tgt[1:0]  = 2'b00;
         if ($urandom_range(0, 7) != 0) epcR[1:0] = 2'b00;
         applyStimulus(($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 15) == 0),
                       epcR,
                       ($urandom_range(0, 3) == 0),
                       tgt,
                       ($urandom_range(0, 2) == 0));
      end

      // Asynchronous reset mid-cycle, no clock edge needed
      applyStimulus(0, 0, 0, 0, 1, 32'h0000_3100, 0);
      checkVal("preResetAddr", bus.Addr, 32'h0000_3100);
      #2;
      reset = 1'b0;
      modelReset();
      #1;
      checkVal("asyncAddr",  bus.Addr, 32'h0000_3000);
      checkVal("asyncValid", {31'h0, bus.valid_D}, 32'h0);
      checkVal("asyncState", {30'h0, dbgState}, 32'h0);
`ifdef FETCH_CNT_EN
      checkVal("asyncCnt",   fetchCnt, 32'h0);
`endif
      @(negedge clock);
      checkOutput();
      reset = 1'b1;
      repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkVal("rebootAddr", bus.Addr, 32'h0000_3010);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "[TB] timeout");
   end

endmodule
